// File: rtl/dcmi_bus_master.sv
// rtl/dcmi_bus_master.sv - round-robin byte bus master feeding an STM32 DCMI port
//
// Purpose: arbitrates N_SRC requesters sharing one 8-bit bus, pulls one byte
// per slot of CLK_DIV clocks from the granted source, and replays the bytes on a
// DCMI-style interface (D, PCLK, HSYNC, VSYNC). Packets are separated by
// GAP_SLOTS idle slots.
//
// Optional feature macro: DCMI_MASTER_FREE_PCLK_EN
//   defined   : slot counter and DCMI_PCLK run continuously, packets start on a slot boundary
//   undefined : DCMI_PCLK toggles only while a packet is being sent
//
// Ports:
//   i_clk          clock, all logic on the rising edge
//   i_rst          asynchronous active-high reset
//   i_dreq         per-source request, held until the source's last byte is accepted
//   o_dack         one-hot grant, the granted source drives i_mdata
//   i_mdata        shared data bus
//   o_dclken       one-cycle byte-accept strobe (source advances on dack & dclken)
//   o_dcmi_d       registered byte toward the DCMI port
//   o_dcmi_pclk    DCMI pixel clock
//   o_dcmi_hsync   high while o_dcmi_d holds a valid byte
//   o_dcmi_vsync   high for the duration of a packet
//   o_busy         high whenever the FSM is not idle
module dcmi_bus_master #(
  parameter int N_SRC     = 2,
  parameter int CLK_DIV   = 4,
  parameter int GAP_SLOTS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_dreq,
  output logic [N_SRC-1:0] o_dack,
  input  logic [7:0]       i_mdata,
  output logic             o_dclken,
  output logic [7:0]       o_dcmi_d,
  output logic             o_dcmi_pclk,
  output logic             o_dcmi_hsync,
  output logic             o_dcmi_vsync,
  output logic             o_busy
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int GW = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_SLOTS - 1);
  localparam logic [SW-1:0] SRC_LAST = SW'(N_SRC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [SW-1:0]    r_sel;
  logic [SW-1:0]    r_rr_ptr;
  logic [N_SRC-1:0] r_dack;
  logic [7:0]       r_d;
  logic             r_valid;
  logic             r_vsync;
  logic             r_pclk;

  logic             w_slot_end;
  logic [CW-1:0]    w_cnt_inc;
  logic [CW-1:0]    w_cnt_nxt;
  logic [1:0]       w_state_nxt;
  logic             w_sel_req;
  logic             w_any_req;
  logic             w_launch;
  logic             w_pclk_nxt;
  logic [SW-1:0]    w_idx;
  logic [SW-1:0]    w_pick;
  logic [SW-1:0]    w_pick_nxt;

  // Round-robin pick: scan from r_rr_ptr upward; iterating from the far end
  // down lets the nearest requester overwrite the others.
  always_comb begin
    w_any_req = |i_dreq;
    w_idx     = r_rr_ptr;
    w_pick    = r_rr_ptr;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      w_idx = SW'((int'(r_rr_ptr) + i) % N_SRC);
      if (i_dreq[w_idx]) begin
        w_pick = w_idx;
      end
    end
    w_pick_nxt = (w_pick == SRC_LAST) ? '0 : w_pick + 1'b1;
  end

  // Next-state / next-count logic, shared by the registers and the PCLK register
  // so that PCLK is a clean flop output aligned with r_cnt.
  always_comb begin
    w_slot_end  = (r_cnt == CNT_LAST);
    w_cnt_inc   = w_slot_end ? '0 : r_cnt + 1'b1;
    w_sel_req   = i_dreq[r_sel];
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef DCMI_MASTER_FREE_PCLK_EN
        // Start only on a wrap so the PCLK phase never jumps.
        w_cnt_nxt = w_cnt_inc;
        w_launch  = w_any_req && w_slot_end;
`else
        w_cnt_nxt = '0;
        w_launch  = w_any_req;
`endif
        if (w_launch) begin
          w_state_nxt = S_SEND;
          w_cnt_nxt   = '0;
        end
      end
      S_SEND: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_slot_end && !w_sel_req) begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_slot_end && (r_gap_cnt == GAP_LAST)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
`ifdef DCMI_MASTER_FREE_PCLK_EN
    w_pclk_nxt = (w_cnt_nxt >= CNT_HALF);
`else
    w_pclk_nxt = (w_state_nxt == S_SEND) && (w_cnt_nxt >= CNT_HALF);
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
      r_sel     <= '0;
      r_rr_ptr  <= '0;
      r_dack    <= '0;
      r_d       <= 8'h00;
      r_valid   <= 1'b0;
      r_vsync   <= 1'b0;
      r_pclk    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pclk  <= w_pclk_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_sel    <= w_pick;
            r_rr_ptr <= w_pick_nxt;
            r_dack   <= N_SRC'(1) << w_pick;
            r_vsync  <= 1'b1;
            r_valid  <= 1'b0;
          end
        end
        S_SEND: begin
          if (w_slot_end) begin
            if (w_sel_req) begin
              // Byte captured now is shown for the whole next slot.
              r_d     <= i_mdata;
              r_valid <= 1'b1;
            end else begin
              r_valid   <= 1'b0;
              r_dack    <= '0;
              r_vsync   <= 1'b0;
              r_gap_cnt <= '0;
            end
          end
        end
        S_GAP: begin
          if (w_slot_end) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_dack  <= '0;
          r_valid <= 1'b0;
          r_vsync <= 1'b0;
        end
      endcase
    end
  end

  assign o_dack       = r_dack;
  assign o_dclken     = (r_state == S_SEND) && w_slot_end && w_sel_req;
  assign o_dcmi_d     = r_d;
  assign o_dcmi_pclk  = r_pclk;
  assign o_dcmi_hsync = r_valid;
  assign o_dcmi_vsync = r_vsync;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_dcmi_bus_master.sv
// tb/tb_dcmi_bus_master.sv - scoreboard bench for dcmi_bus_master
module tb_dcmi_bus_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dreq = 2'b00;
  logic [1:0] dack;
  logic [7:0] mdata = 8'hEE;
  logic       dclken;
  logic [7:0] d;
  logic       pclk;
  logic       hsync;
  logic       vsync;
  logic       busy;

  always #5 clk = ~clk;

  dcmi_bus_master #(.N_SRC(2), .CLK_DIV(4), .GAP_SLOTS(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_dreq       (dreq),
    .o_dack       (dack),
    .i_mdata      (mdata),
    .o_dclken     (dclken),
    .o_dcmi_d     (d),
    .o_dcmi_pclk  (pclk),
    .o_dcmi_hsync (hsync),
    .o_dcmi_vsync (vsync),
    .o_busy       (busy)
  );

`ifdef DCMI_MASTER_FREE_PCLK_EN
  localparam int EXP_GAP     = 20;
  localparam int EXP_IDLE_HI = 50;
  localparam int EXP_IDLE_RS = 25;
`else
  localparam int EXP_GAP     = 17;
  localparam int EXP_IDLE_HI = 0;
  localparam int EXP_IDLE_RS = 0;
`endif

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_data[2][8];
  int         src_len[2];
  int         src_pos[2];

  int         c_dclken, c_vs, c_hs, c_pclk_hi, c_pclk_rise, low_run, last_gap;
  logic [1:0] dack_or;
  logic       prev_pclk = 1'b0;
  logic       prev_vs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    c_dclken = 0; c_vs = 0; c_hs = 0; c_pclk_hi = 0; c_pclk_rise = 0;
    dack_or = 2'b00;
  endtask

  task automatic load(input int s, input logic [7:0] first, input int len);
    for (int i = 0; i < 8; i++) src_data[s][i] = first + 8'(i);
    src_len[s] = len;
    src_pos[s] = 0;
    for (int i = 0; i < len; i++) exp_q.push_back(first + 8'(i));
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    @(posedge clk); #1;
    while ((busy || dreq != 2'b00) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_timeout"}, {31'd0, n < budget}, 32'd1);
  endtask

  // Monitor: invariants every cycle, byte scoreboard on each PCLK rise.
  initial begin : monitor
    clr();
    low_run = 0;
    last_gap = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("dack_onehot0", {31'd0, $onehot0(dack)}, 32'd1);
        check("dclken_only_busy", {31'd0, dclken && !busy}, 32'd0);
        check("hsync_within_vsync", {31'd0, hsync && !vsync}, 32'd0);
        if (dclken) c_dclken++;
        if (vsync) c_vs++;
        if (hsync) c_hs++;
        if (pclk) c_pclk_hi++;
        dack_or = dack_or | dack;
        if (pclk && !prev_pclk) begin
          c_pclk_rise++;
          if (hsync) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL byte_unexpected: got 0x%0h, expected no byte", d);
            end else begin
              check("dcmi_d", {24'd0, d}, {24'd0, exp_q.pop_front()});
            end
          end
        end
        if (vsync && !prev_vs) last_gap = low_run;
        if (vsync) low_run = 0; else low_run++;
      end
      prev_pclk = pclk;
      prev_vs   = vsync;
    end
  end

  // Source model: drives the granted source's current byte, advances on accept,
  // drops its request once its last byte has been taken.
  initial begin : sources
    logic       acc;
    logic [1:0] accd;
    forever begin
      @(negedge clk);
      acc  = dclken;
      accd = dack;
      @(posedge clk); #1;
      if (acc && !rst) begin
        for (int s = 0; s < 2; s++) begin
          if (accd[s]) begin
            src_pos[s]++;
            if (src_pos[s] >= src_len[s]) dreq[s] = 1'b0;
          end
        end
      end
      mdata = 8'hEE;
      for (int s = 0; s < 2; s++) begin
        if (dack[s]) mdata = src_data[s][src_pos[s] % 8];
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    for (int s = 0; s < 2; s++) begin
      src_len[s] = 0;
      src_pos[s] = 0;
      for (int i = 0; i < 8; i++) src_data[s][i] = 8'h00;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dack", {30'd0, dack}, 32'd0);
    check("rst_dclken", {31'd0, dclken}, 32'd0);
    check("rst_d", {24'd0, d}, 32'd0);
    check("rst_pclk", {31'd0, pclk}, 32'd0);
    check("rst_hsync", {31'd0, hsync}, 32'd0);
    check("rst_vsync", {31'd0, vsync}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Four-byte counter packet from source 0
    load(0, 8'h00, 4);
    clr();
    dreq[0] = 1'b1;
    wait_done("t1", 200);
    check("t1_dclken", c_dclken, 32'd4);
    check("t1_vsync_cycles", c_vs, 32'd20);
    check("t1_hsync_cycles", c_hs, 32'd16);
    check("t1_dack_seen", {30'd0, dack_or}, 32'd1);
    check("t1_drained", exp_q.size(), 32'd0);

    // Simultaneous requests right after reset: source 0 first, then 1
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    load(0, 8'h10, 2);
    load(1, 8'hA0, 3);
    clr();
    dreq = 2'b11;
    wait_done("t2", 400);
    check("t2_dclken", c_dclken, 32'd5);
    check("t2_hsync_cycles", c_hs, 32'd20);
    check("t2_vsync_cycles", c_vs, 32'd28);
    check("t2_gap_cycles", last_gap, EXP_GAP);
    check("t2_dack_seen", {30'd0, dack_or}, 32'd3);
    check("t2_drained", exp_q.size(), 32'd0);

    // Zero-length packet from source 1
    src_len[1] = 0;
    src_pos[1] = 0;
    clr();
    dreq[1] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!busy && n < 20);
    check("t3_start_timeout", {31'd0, n < 20}, 32'd1);
    @(posedge clk); #1;
    dreq[1] = 1'b0;
    wait_done("t3", 200);
    check("t3_dclken", c_dclken, 32'd0);
    check("t3_hsync_cycles", c_hs, 32'd0);
    check("t3_vsync_cycles", c_vs, 32'd4);
    check("t3_dack_seen", {30'd0, dack_or}, 32'd2);

    // Reset during the second byte, then a clean packet
    load(0, 8'h20, 4);
    clr();
    dreq[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d == 8'h21 && hsync && pclk) && n < 200);
    check("t4_byte2_timeout", {31'd0, n < 200}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t4_rst_dack", {30'd0, dack}, 32'd0);
    check("t4_rst_vsync", {31'd0, vsync}, 32'd0);
    check("t4_rst_hsync", {31'd0, hsync}, 32'd0);
    check("t4_rst_pclk", {31'd0, pclk}, 32'd0);
    check("t4_rst_d", {24'd0, d}, 32'd0);
    check("t4_rst_dclken", {31'd0, dclken}, 32'd0);
    @(posedge clk); #2;
    dreq = 2'b00;
    src_pos[0] = 0;
    check("t4_abandoned_bytes", exp_q.size(), 32'd2);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    load(0, 8'h00, 2);
    clr();
    dreq[0] = 1'b1;
    wait_done("t4", 200);
    check("t4_dclken", c_dclken, 32'd2);
    check("t4_dack_seen", {30'd0, dack_or}, 32'd1);
    check("t4_drained", exp_q.size(), 32'd0);

    // Idle behaviour of PCLK and DACK
    clr();
    repeat (100) @(posedge clk);
    #1;
    check("t5_pclk_high_cycles", c_pclk_hi, EXP_IDLE_HI);
    check("t5_pclk_rises", c_pclk_rise, EXP_IDLE_RS);
    check("t5_dack_seen", {30'd0, dack_or}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcmi_bus_master.md
DCMI_BUS_MASTER -- requirements
Module: dcmi_bus_master

Interface
REQ-001 Parameter N_SRC, default 2: number of requesters on the multiplexed bus (1..8).
REQ-002 Parameter CLK_DIV, default 4: CLK cycles per byte slot and per DCMI_PCLK period (even, >=2).
REQ-003 Parameter GAP_SLOTS, default 4: idle slots enforced between packets (>=1).
REQ-004 CLK  input  1  global clock; all logic on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 DREQ  input  N_SRC  per-source bus request; a source holds it high until its last byte is accepted.
REQ-007 DACK  output  N_SRC  one-hot grant; the granted source drives MDATA.
REQ-008 MDATA  input  8  shared multiplexed data; valid whenever any DACK bit is high.
REQ-009 DCLKEN  output  1  one-cycle byte-accept strobe; the granted source advances on DACK&&DCLKEN.
REQ-010 DCMI_D  output  8  registered byte toward the STM32 DCMI port.
REQ-011 DCMI_PCLK  output  1  DCMI pixel clock; DCMI_D is stable around its rising edge.
REQ-012 DCMI_HSYNC  output  1  active high while DCMI_D holds a valid byte.
REQ-013 DCMI_VSYNC  output  1  active high for the duration of a packet.
REQ-014 BUSY  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, SEND, GAP; slot counter cnt counts 0..CLK_DIV-1 and wraps in SEND and GAP.
REQ-016 IDLE: when any DREQ bit is high, select the source by round-robin starting at the index after the last served source (index 0 after reset), set DACK one-hot, clear cnt, go to SEND.
REQ-017 In IDLE, GAP and reset, DACK is all zero so no source drives MDATA.
REQ-018 DCLKEN = (state==SEND) && (cnt==CLK_DIV-1) && DREQ[sel], combinational; never high outside SEND.
REQ-019 On each SEND slot end (cnt==CLK_DIV-1): if DREQ[sel], DCMI_D <= MDATA and the valid flag <= 1; otherwise the valid flag <= 0, DACK <= 0, state <= GAP.
REQ-020 DCMI_HSYNC equals the valid flag, so each byte is presented for exactly one full slot, including the last byte.
REQ-021 DCMI_VSYNC is registered: set on IDLE->SEND, cleared on SEND->GAP.
REQ-022 DCMI_PCLK is low for cnt in 0..CLK_DIV/2-1 and high for cnt in CLK_DIV/2..CLK_DIV-1; DCMI_D changes only at cnt wrap.
REQ-023 GAP: remain for GAP_SLOTS complete slots with VSYNC, HSYNC and DACK low, then go to IDLE.
REQ-024 DREQ[sel] low at the first slot end gives a zero-length packet: no DCLKEN, HSYNC never asserted, VSYNC high for one slot.
REQ-025 Changes on non-selected DREQ bits during SEND or GAP are ignored until the next IDLE evaluation.
REQ-026 Simultaneous requests are served one packet each in round-robin order; no source is served twice while another is waiting.

Reset
REQ-027 While RST is high: state IDLE, cnt 0, DACK 0, DCLKEN 0, DCMI_D 0x00, DCMI_PCLK 0, DCMI_HSYNC 0, DCMI_VSYNC 0, BUSY 0, round-robin pointer 0.
REQ-028 RST asserted mid-packet takes effect immediately (asynchronously); the packet is abandoned and operation restarts from IDLE on the first edge after release.

Configuration
REQ-029 Macro DCMI_MASTER_FREE_PCLK_EN defined: cnt also runs in IDLE and DCMI_PCLK toggles continuously with the REQ-022 waveform; IDLE->SEND waits for a cnt wrap so the slot phase stays continuous.
REQ-030 Macro DCMI_MASTER_FREE_PCLK_EN not defined: DCMI_PCLK is held low in IDLE and GAP and toggles only in SEND.

Verification
REQ-031 N_SRC=2, CLK_DIV=4; source 0 sends a 4-byte counter packet 00..03 -> DCMI_D shows 00,01,02,03 on four consecutive PCLK rises with HSYNC high; exactly 4 DCLKEN pulses; VSYNC falls after byte 03's slot.
REQ-032 DREQ[0] and DREQ[1] raised in the same cycle after reset -> source 0 is served first, then source 1 after 4 GAP slots; DACK is never 2'b11.
REQ-033 Source 1 raises and drops DREQ before the first slot end -> zero DCLKEN, HSYNC stays 0, VSYNC is high for exactly 4 CLK cycles.
REQ-034 RST pulsed during the second byte of a packet -> DACK, VSYNC, HSYNC and PCLK go to 0 before the next CLK edge; a new packet after release starts cleanly from byte 00.
REQ-035 With DCMI_MASTER_FREE_PCLK_EN defined, over 100 idle cycles -> PCLK period is 4 CLK with 50% duty and DACK stays 0; without the macro, PCLK stays 0.
